// File: rtl/overlay_scheduler_if.sv
// ROM-side bus of the overlay scheduler: enable/address out, read data back,
// one group per image ROM (fire icon, warning icon, digit glyphs).
interface overlay_scheduler_if;
    logic        o_fire_ena;
    logic [13:0] o_fire_addr;
    logic [11:0] i_fire_data;
    logic        o_warn_ena;
    logic [13:0] o_warn_addr;
    logic [11:0] i_warn_data;
    logic        o_digit_ena;
    logic [16:0] o_digit_addr;
    logic        i_digit_bit;

    modport master (
        output o_fire_ena, o_fire_addr, o_warn_ena, o_warn_addr, o_digit_ena, o_digit_addr,
        input  i_fire_data, i_warn_data, i_digit_bit
    );

    modport slave (
        input  o_fire_ena, o_fire_addr, o_warn_ena, o_warn_addr, o_digit_ena, o_digit_addr,
        output i_fire_data, i_warn_data, i_digit_bit
    );
endinterface

// File: rtl/overlay_scheduler.sv
// Overlay sequencer: per-frame alarm/digit latch, alarm FSM, direct ROM addressing and a
// fixed two-strobe colour pipeline. Define OVERLAY_BLINK_EN to blink the fire icon in hold.
module overlay_scheduler #(
    parameter int FIRE_X0     = 520,
    parameter int WARN_X0     = 400,
    parameter int ICON_Y0     = 0,
    parameter int ICON_W      = 120,
    parameter int ICON_H      = 120,
    parameter int DIGIT_X0    = 320,
    parameter int DIGIT_Y0    = 150,
    parameter int DIGIT_W     = 80,
    parameter int DIGIT_H     = 120,
    parameter int HOLD_FRAMES = 60
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_pix_en,
    input  logic [10:0]                 i_x,
    input  logic [9:0]                  i_y,
    input  logic                        i_is_fire,
    input  logic                        i_is_warning,
    input  logic [3:0]                  i_tens,
    input  logic [3:0]                  i_ones,
    overlay_scheduler_if.master         rom,
    output logic [3:0]                  o_red,
    output logic [3:0]                  o_green,
    output logic [3:0]                  o_blue,
    output logic                        o_frame_start
);

    localparam int HOLD_W = $clog2(HOLD_FRAMES + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_WARN, ST_FIRE, ST_HOLD} state_t;
    typedef enum logic [2:0] {TAG_BG, TAG_FIRE, TAG_WARN, TAG_TENS, TAG_ONES} tag_t;

    state_t              state, state_nxt, state_eff;
    logic [HOLD_W-1:0]   hold_cnt, hold_nxt;
    logic                warn_sh, seen;
    logic [3:0]          tens_sh, ones_sh;
    logic                latch;
    logic                warn_eff, seen_eff;
    logic [3:0]          tens_eff, ones_eff;
    logic                fire_vis, warn_vis;
    logic [10:0]         fire_dx, warn_dx, tens_dx, ones_dx, glyph_dx;
    logic [9:0]          icon_dy, digit_dy;
    logic                fire_in, warn_in, tens_in, ones_in;
    logic [3:0]          glyph_c;
    tag_t                tag_c, tag_p1;
    logic [11:0]         colour_c, colour_p2;

    function automatic logic [13:0] icon_addr(input logic [6:0] dy, input logic [6:0] dx);
        return {7'd0, dy} * 14'(ICON_W) + {7'd0, dx};
    endfunction

    function automatic logic [16:0] digit_addr(input logic [3:0] g, input logic [6:0] dy,
                                               input logic [6:0] dx);
        return {13'd0, g} * 17'(DIGIT_W * DIGIT_H) + {10'd0, dy} * 17'(DIGIT_W) + {10'd0, dx};
    endfunction

    assign latch = i_pix_en && (i_x == 11'd0) && (i_y == 10'd0);

    // The latch strobe's own pixel already sees the freshly latched values.
    assign state_eff = latch ? state_nxt    : state;
    assign warn_eff  = latch ? i_is_warning : warn_sh;
    assign tens_eff  = latch ? i_tens       : tens_sh;
    assign ones_eff  = latch ? i_ones       : ones_sh;
    assign seen_eff  = latch | seen;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= ST_IDLE;
            hold_cnt <= '0;
        end else if (latch) begin
            state    <= state_nxt;
            hold_cnt <= hold_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        hold_nxt  = hold_cnt;
        case (state)
            ST_IDLE: begin
                if (i_is_fire)         state_nxt = ST_FIRE;
                else if (i_is_warning) state_nxt = ST_WARN;
            end
            ST_WARN: begin
                if (i_is_fire)          state_nxt = ST_FIRE;
                else if (!i_is_warning) state_nxt = ST_IDLE;
            end
            ST_FIRE: begin
                if (!i_is_fire) begin
                    state_nxt = ST_HOLD;
                    hold_nxt  = HOLD_W'(HOLD_FRAMES - 1);
                end
            end
            ST_HOLD: begin
                if (i_is_fire)             state_nxt = ST_FIRE;
                else if (hold_cnt == '0)   state_nxt = i_is_warning ? ST_WARN : ST_IDLE;
                else                       hold_nxt  = hold_cnt - 1'b1;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

`ifdef OVERLAY_BLINK_EN
    logic [4:0] blink_cnt, blink_eff;

    always_ff @(posedge i_clk) begin
        if (i_rst)      blink_cnt <= '0;
        else if (latch) blink_cnt <= blink_cnt + 5'd1;
    end

    assign blink_eff = latch ? blink_cnt + 5'd1 : blink_cnt;
    assign fire_vis  = (state_eff == ST_FIRE) || ((state_eff == ST_HOLD) && !blink_eff[4]);
`else
    assign fire_vis  = (state_eff == ST_FIRE) || (state_eff == ST_HOLD);
`endif

    assign warn_vis = (state_eff == ST_WARN) ||
                      (((state_eff == ST_FIRE) || (state_eff == ST_HOLD)) && warn_eff);

    // Wrapping subtraction folds both region bounds into one unsigned compare.
    assign fire_dx  = i_x - 11'(FIRE_X0);
    assign warn_dx  = i_x - 11'(WARN_X0);
    assign tens_dx  = i_x - 11'(DIGIT_X0);
    assign ones_dx  = i_x - 11'(DIGIT_X0 + DIGIT_W);
    assign icon_dy  = i_y - 10'(ICON_Y0);
    assign digit_dy = i_y - 10'(DIGIT_Y0);

    assign fire_in = (fire_dx < 11'(ICON_W))  && (icon_dy  < 10'(ICON_H));
    assign warn_in = (warn_dx < 11'(ICON_W))  && (icon_dy  < 10'(ICON_H));
    assign tens_in = (tens_dx < 11'(DIGIT_W)) && (digit_dy < 10'(DIGIT_H));
    assign ones_in = (ones_dx < 11'(DIGIT_W)) && (digit_dy < 10'(DIGIT_H));

    always_comb begin
        tag_c = TAG_BG;
        if (seen_eff) begin
            if (fire_vis && fire_in)                                   tag_c = TAG_FIRE;
            else if (warn_vis && warn_in)                              tag_c = TAG_WARN;
            else if (tens_in && (tens_eff != 4'd0) && (tens_eff <= 4'd9)) tag_c = TAG_TENS;
            else if (ones_in && (ones_eff <= 4'd9))                    tag_c = TAG_ONES;
        end
    end

    assign glyph_c  = (tag_c == TAG_TENS) ? tens_eff : ones_eff;
    assign glyph_dx = (tag_c == TAG_TENS) ? tens_dx  : ones_dx;

    always_comb begin
        colour_c = 12'h000;
        case (tag_p1)
            TAG_FIRE:           colour_c = rom.i_fire_data;
            TAG_WARN:           colour_c = rom.i_warn_data;
            TAG_TENS, TAG_ONES: colour_c = rom.i_digit_bit ? 12'h000 : 12'hFFF;
            default:            colour_c = 12'h000;
        endcase
    end

    assign rom.o_fire_ena  = (tag_p1 == TAG_FIRE);
    assign rom.o_warn_ena  = (tag_p1 == TAG_WARN);
    assign rom.o_digit_ena = (tag_p1 == TAG_TENS) || (tag_p1 == TAG_ONES);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            warn_sh          <= 1'b0;
            tens_sh          <= '0;
            ones_sh          <= '0;
            seen             <= 1'b0;
            o_frame_start    <= 1'b0;
            tag_p1           <= TAG_BG;
            rom.o_fire_addr  <= '0;
            rom.o_warn_addr  <= '0;
            rom.o_digit_addr <= '0;
            colour_p2        <= '0;
            o_red            <= '0;
            o_green          <= '0;
            o_blue           <= '0;
        end else begin
            o_frame_start <= latch;
            if (latch) begin
                warn_sh <= i_is_warning;
                tens_sh <= i_tens;
                ones_sh <= i_ones;
                seen    <= 1'b1;
            end
            if (i_pix_en) begin
                // Stage 1: region tag and direct ROM address
                tag_p1 <= tag_c;
                if (tag_c == TAG_FIRE)
                    rom.o_fire_addr <= icon_addr(icon_dy[6:0], fire_dx[6:0]);
                if (tag_c == TAG_WARN)
                    rom.o_warn_addr <= icon_addr(icon_dy[6:0], warn_dx[6:0]);
                if ((tag_c == TAG_TENS) || (tag_c == TAG_ONES))
                    rom.o_digit_addr <= digit_addr(glyph_c, digit_dy[6:0], glyph_dx[6:0]);
                // Stage 2: colour select from ROM data
                colour_p2 <= colour_c;
                // Stage 3: output register
                {o_red, o_green, o_blue} <= colour_p2;
            end
        end
    end

endmodule

// File: tb/tb_overlay_scheduler.sv
// Directed bench for overlay_scheduler: reset, addressing, priority, digits, frame latch and hold FSM.
module tb_overlay_scheduler;
    logic        clk = 1'b0;
    logic        rst, pix_en, fire, warn;
    logic [10:0] x;
    logic [9:0]  y;
    logic [3:0]  tens, ones, r, g, b;
    logic        fs;
    int          n_vec = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    overlay_scheduler_if rom_if();

    overlay_scheduler dut (
        .i_clk(clk), .i_rst(rst), .i_pix_en(pix_en), .i_x(x), .i_y(y),
        .i_is_fire(fire), .i_is_warning(warn), .i_tens(tens), .i_ones(ones),
        .rom(rom_if), .o_red(r), .o_green(g), .o_blue(b), .o_frame_start(fs)
    );

    // ROM models: one-clock read latency, contents derived from the address.
    always @(posedge clk) begin
        if (rom_if.o_fire_ena)  rom_if.i_fire_data <= rom_if.o_fire_addr[11:0] ^ 12'hA5A;
        if (rom_if.o_warn_ena)  rom_if.i_warn_data <= rom_if.o_warn_addr[11:0] ^ 12'h3C3;
        if (rom_if.o_digit_ena) rom_if.i_digit_bit <= rom_if.o_digit_addr[0];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic pix(input int px, input int py);
        @(negedge clk);
        pix_en = 1'b1;
        x = 11'(px);
        y = 10'(py);
        @(negedge clk);
        pix_en = 1'b0;
    endtask

    task automatic latch_frame(input logic f, input logic w, input logic [3:0] t, input logic [3:0] o);
        fire = f; warn = w; tens = t; ones = o;
        pix(0, 0);
    endtask

    task automatic hold_check(input string pre, input logic w_end);
        for (int k = 1; k <= 60; k++) begin
            latch_frame(1'b0, 1'b0, 4'd0, 4'd0);
            pix(520, 0);
            chk($sformatf("%s_hold%0d", pre, k), {31'd0, rom_if.o_fire_ena}, 32'd1);
        end
        latch_frame(1'b0, w_end, 4'd0, 4'd0);
        pix(520, 0);
        chk({pre, "_expired"}, {31'd0, rom_if.o_fire_ena}, 32'd0);
        pix(400, 0);
        chk({pre, "_after_warn"}, {31'd0, rom_if.o_warn_ena}, {31'd0, w_end});
    endtask

    initial begin
        rst = 1'b1; pix_en = 1'b0; x = '0; y = '0;
        fire = 1'b0; warn = 1'b0; tens = '0; ones = '0;
        repeat (3) @(negedge clk);
        chk("rst_rgb",       {20'd0, r, g, b}, 32'd0);
        chk("rst_fire_ena",  {31'd0, rom_if.o_fire_ena}, 32'd0);
        chk("rst_warn_ena",  {31'd0, rom_if.o_warn_ena}, 32'd0);
        chk("rst_digit_ena", {31'd0, rom_if.o_digit_ena}, 32'd0);
        chk("rst_fire_addr", {18'd0, rom_if.o_fire_addr}, 32'd0);
        chk("rst_digit_addr", {15'd0, rom_if.o_digit_addr}, 32'd0);
        chk("rst_fs",        {31'd0, fs}, 32'd0);
        rst = 1'b0;

        // First frame with fire
        latch_frame(1'b1, 1'b0, 4'd4, 4'd7);
        chk("frame_start", {31'd0, fs}, 32'd1);
        pix(520, 0);
        chk("fire_ena_a", {31'd0, rom_if.o_fire_ena}, 32'd1);
        chk("fire_addr_a", {18'd0, rom_if.o_fire_addr}, 32'd0);
        chk("fs_drop", {31'd0, fs}, 32'd0);
        pix(100, 100);
        chk("fire_ena_off", {31'd0, rom_if.o_fire_ena}, 32'd0);
        chk("rgb_lat1", {20'd0, r, g, b}, 32'h000);
        pix(100, 100);
        chk("rgb_fire0", {20'd0, r, g, b}, 32'hA5A);
        pix(521, 0);
        pix(522, 0);
        chk("fire_addr_2", {18'd0, rom_if.o_fire_addr}, 32'd2);
        pix(523, 0);
        chk("rgb_fire1", {20'd0, r, g, b}, 32'hA5B);

        // Reset mid-frame with a strobe present
        @(negedge clk);
        rst = 1'b1; pix_en = 1'b1; x = 11'd524; y = 10'd0;
        @(negedge clk);
        rst = 1'b0; pix_en = 1'b0;
        chk("mrst_rgb", {20'd0, r, g, b}, 32'd0);
        chk("mrst_fire_ena", {31'd0, rom_if.o_fire_ena}, 32'd0);
        chk("mrst_fire_addr", {18'd0, rom_if.o_fire_addr}, 32'd0);
        pix(520, 0);
        chk("no_sprite_pre_latch", {31'd0, rom_if.o_fire_ena}, 32'd0);

        // Fire + warning, icon address corners
        latch_frame(1'b1, 1'b1, 4'd4, 4'd7);
        pix(520, 0);
        chk("fw_fire_addr0", {18'd0, rom_if.o_fire_addr}, 32'd0);
        chk("fw_fire_ena", {31'd0, rom_if.o_fire_ena}, 32'd1);
        pix(639, 119);
        chk("fw_fire_addr_last", {18'd0, rom_if.o_fire_addr}, 32'd14399);
        pix(400, 0);
        chk("fw_warn_ena", {31'd0, rom_if.o_warn_ena}, 32'd1);
        chk("fw_warn_addr0", {18'd0, rom_if.o_warn_addr}, 32'd0);
        chk("fw_fire_ena_off", {31'd0, rom_if.o_fire_ena}, 32'd0);
        chk("fw_fire_addr_held", {18'd0, rom_if.o_fire_addr}, 32'd14399);
        chk("fw_rgb_520_0", {20'd0, r, g, b}, 32'hA5A);
        pix(0, 200);
        chk("fw_rgb_639_119", {20'd0, r, g, b}, 32'h265);
        pix(0, 200);
        chk("fw_rgb_400_0", {20'd0, r, g, b}, 32'h3C3);

        // Digits 4 and 7
        latch_frame(1'b0, 1'b0, 4'd4, 4'd7);
        pix(320, 150);
        chk("tens_ena", {31'd0, rom_if.o_digit_ena}, 32'd1);
        chk("tens_addr0", {15'd0, rom_if.o_digit_addr}, 32'd38400);
        pix(399, 269);
        chk("tens_addr_last", {15'd0, rom_if.o_digit_addr}, 32'd47999);
        pix(400, 150);
        chk("ones_addr0", {15'd0, rom_if.o_digit_addr}, 32'd67200);
        chk("rgb_tens_paper", {20'd0, r, g, b}, 32'hFFF);
        pix(479, 269);
        chk("ones_addr_last", {15'd0, rom_if.o_digit_addr}, 32'd76799);
        chk("rgb_tens_ink", {20'd0, r, g, b}, 32'h000);
        pix(480, 150);
        chk("digit_ena_off", {31'd0, rom_if.o_digit_ena}, 32'd0);
        chk("digit_addr_held", {15'd0, rom_if.o_digit_addr}, 32'd76799);
        chk("rgb_ones_paper", {20'd0, r, g, b}, 32'hFFF);

        // Blank digits: tens==0, ones>9
        latch_frame(1'b0, 1'b0, 4'd0, 4'd7);
        pix(320, 150);
        chk("tens0_ena", {31'd0, rom_if.o_digit_ena}, 32'd0);
        pix(400, 150);
        chk("tens0_ones_ena", {31'd0, rom_if.o_digit_ena}, 32'd1);
        pix(0, 200);
        chk("tens0_rgb", {20'd0, r, g, b}, 32'h000);
        latch_frame(1'b0, 1'b0, 4'd4, 4'd12);
        pix(400, 150);
        chk("ones12_ena", {31'd0, rom_if.o_digit_ena}, 32'd0);
        pix(320, 150);
        chk("ones12_tens_addr", {15'd0, rom_if.o_digit_addr}, 32'd38400);

        // Fresh start for FSM timing
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        latch_frame(1'b0, 1'b0, 4'd0, 4'd0);
        fire = 1'b1;
        pix(520, 0);
        chk("midframe_fire_ignored", {31'd0, rom_if.o_fire_ena}, 32'd0);
        latch_frame(1'b1, 1'b0, 4'd0, 4'd0);
        pix(520, 0);
        chk("fire_on", {31'd0, rom_if.o_fire_ena}, 32'd1);
        hold_check("h1", 1'b0);

        // Re-assert during hold, then a full fresh hold ending in WARN
        latch_frame(1'b1, 1'b0, 4'd0, 4'd0);
        pix(520, 0);
        chk("re_fire", {31'd0, rom_if.o_fire_ena}, 32'd1);
        latch_frame(1'b0, 1'b0, 4'd0, 4'd0);
        pix(520, 0);
        chk("re_hold_a", {31'd0, rom_if.o_fire_ena}, 32'd1);
        latch_frame(1'b0, 1'b0, 4'd0, 4'd0);
        pix(520, 0);
        chk("re_hold_b", {31'd0, rom_if.o_fire_ena}, 32'd1);
        latch_frame(1'b1, 1'b0, 4'd0, 4'd0);
        pix(520, 0);
        chk("re_fire_nogap", {31'd0, rom_if.o_fire_ena}, 32'd1);
        hold_check("h2", 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
